// File: rtl/wb_arbiter.sv
// Write-back port arbiter: the pipeline owns the register-file write port, and a 2-entry
// queue of multicycle results drains into idle slots, with kill-on-overwrite and starvation stall.
module wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PipeValid,
   input  logic        PipeRegWrite,
   input  logic [4:0]  PipeDest,
   input  logic [31:0] PipeData,
   input  logic        MdValid,
   input  logic [4:0]  MdDest,
   input  logic [31:0] MdData,
   output logic        MdReady,
   output logic        RegWrite,
   output logic [4:0]  RegDest,
   output logic [31:0] RegData,
   output logic        StallReq,
   output logic [31:0] PendingMask
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
   } entry_t;

   entry_t          q0, q1, n_q0, n_q1, md_e;
   logic [1:0]      cnt, n_cnt;
   logic [CW-1:0]   wait_cnt, n_wait;
   logic            busy, pop, accept, push, keep0, keep1;

   // Queue and starvation-counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         q0       <= '0;
         q1       <= '0;
         cnt      <= 2'd0;
         wait_cnt <= '0;
      end else begin
         q0       <= n_q0;
         q1       <= n_q1;
         cnt      <= n_cnt;
         wait_cnt <= n_wait;
      end
   end

   // Arbitration, kill/compaction, and port outputs
   always_comb begin
      busy        = PipeValid && PipeRegWrite && (PipeDest != 5'd0);
      MdReady     = !rst && (cnt < 2'd2);
      accept      = MdValid && MdReady;
      // A same-cycle pipeline write to the same register is younger, so the offer dies here
      push        = accept && (MdDest != 5'd0) && !(busy && (MdDest == PipeDest));
      pop         = !busy && (cnt != 2'd0);
      keep0       = (cnt != 2'd0) && !pop && !(busy && (q0.dest == PipeDest));
      keep1       = (cnt == 2'd2) && !(busy && (q1.dest == PipeDest));
      md_e        = '{dest: MdDest, data: MdData};
      n_q0        = q0;
      n_q1        = q1;
      n_cnt       = 2'd0;
      n_wait      = wait_cnt;
      RegWrite    = 1'b0;
      RegDest     = 5'd0;
      RegData     = 32'd0;
      StallReq    = 1'b0;
      PendingMask = 32'd0;

      // Survivors compact toward slot 0 in order; the new result goes behind them
      if (keep0) begin
         if (keep1) begin
            n_q1  = q1;
            n_cnt = 2'd2;
         end else if (push) begin
            n_q1  = md_e;
            n_cnt = 2'd2;
         end else begin
            n_cnt = 2'd1;
         end
      end else if (keep1) begin
         n_q0 = q1;
         if (push) begin
            n_q1  = md_e;
            n_cnt = 2'd2;
         end else begin
            n_cnt = 2'd1;
         end
      end else if (push) begin
         n_q0  = md_e;
         n_cnt = 2'd1;
      end

      if (pop || (n_cnt == 2'd0)) begin
         n_wait = '0;
      end else if (wait_cnt != CW'(STARVE_LIMIT)) begin
         n_wait = wait_cnt + CW'(1);
      end

      if (!rst) begin
         if (busy) begin
            RegWrite = 1'b1;
            RegDest  = PipeDest;
            RegData  = PipeData;
         end else if (cnt != 2'd0) begin
            RegWrite = 1'b1;
            RegDest  = q0.dest;
            RegData  = q0.data;
         end
         StallReq = (wait_cnt == CW'(STARVE_LIMIT));
         if (cnt != 2'd0) PendingMask[q0.dest] = 1'b1;
         if (cnt == 2'd2) PendingMask[q1.dest] = 1'b1;
         PendingMask[0] = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        PipeValid, PipeRegWrite;
   logic [4:0]  PipeDest;
   logic [31:0] PipeData;
   logic        MdValid;
   logic [4:0]  MdDest;
   logic [31:0] MdData;
   logic        MdReady, RegWrite, StallReq;
   logic [4:0]  RegDest;
   logic [31:0] RegData, PendingMask;

   int errors = 0;
   int checks = 0;

   wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .PipeValid(PipeValid), .PipeRegWrite(PipeRegWrite), .PipeDest(PipeDest), .PipeData(PipeData),
      .MdValid(MdValid), .MdDest(MdDest), .MdData(MdData), .MdReady(MdReady),
      .RegWrite(RegWrite), .RegDest(RegDest), .RegData(RegData),
      .StallReq(StallReq), .PendingMask(PendingMask)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic prw, input logic [4:0] pd, input logic [31:0] pdat,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdat);
      PipeValid = pv; PipeRegWrite = prw; PipeDest = pd; PipeData = pdat;
      MdValid = mv; MdDest = md; MdData = mdat;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input string tag, input logic we, input logic [4:0] d, input logic [31:0] dat);
      chk({tag, "_we"}, 32'(RegWrite), 32'(we));
      chk({tag, "_dest"}, 32'(RegDest), 32'(d));
      chk({tag, "_data"}, RegData, dat);
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk); #1;
      // Reset cycle: everything quiet even with busy pipe and an offer
      drive(1, 1, 5'd3, 32'h1234, 1, 5'd9, 32'h9);
      wr("rst", 0, 5'd0, 32'd0);
      chk("rst_ready", 32'(MdReady), 32'd0);
      chk("rst_stall", 32'(StallReq), 32'd0);
      chk("rst_mask", PendingMask, 32'd0);
      tick();
      rst = 1'b0;

      // Minimum-latency drain through an idle slot
      drive(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
      chk("t1_ready", 32'(MdReady), 32'd1);
      wr("t1_c0", 0, 5'd0, 32'd0);
      chk("t1_c0_mask", PendingMask, 32'd0);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t1_c1", 1, 5'd5, 32'hDEADBEEF);
      chk("t1_c1_mask", PendingMask, 32'h0000_0020);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t1_c2", 0, 5'd0, 32'd0);
      chk("t1_c2_mask", PendingMask, 32'd0);
      tick();

      // Busy pipeline, back-to-back offers, starvation stall then drain
      drive(1, 1, 5'd1, 32'hA0, 1, 5'd3, 32'h33);
      wr("t2_c0", 1, 5'd1, 32'hA0);
      chk("t2_c0_ready", 32'(MdReady), 32'd1);
      tick();
      drive(1, 1, 5'd1, 32'hA0, 1, 5'd4, 32'h44);
      chk("t2_c1_ready", 32'(MdReady), 32'd1);
      chk("t2_c1_mask", PendingMask, 32'h0000_0008);
      chk("t2_c1_stall", 32'(StallReq), 32'd0);
      tick();
      drive(1, 1, 5'd1, 32'hA0, 1, 5'd6, 32'h66);
      chk("t2_c2_ready", 32'(MdReady), 32'd0);
      chk("t2_c2_mask", PendingMask, 32'h0000_0018);
      chk("t2_c2_stall", 32'(StallReq), 32'd0);
      tick();
      drive(1, 1, 5'd1, 32'hA0, 0, 5'd0, 32'd0);
      chk("t2_c3_stall", 32'(StallReq), 32'd0);
      tick();
      drive(1, 1, 5'd1, 32'hA0, 0, 5'd0, 32'd0);
      chk("t2_c4_stall", 32'(StallReq), 32'd1);
      wr("t2_c4", 1, 5'd1, 32'hA0);
      tick();
      drive(1, 1, 5'd1, 32'hA1, 0, 5'd0, 32'd0);
      chk("t2_c5_stall", 32'(StallReq), 32'd1);
      wr("t2_c5", 1, 5'd1, 32'hA1);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t2_c6", 1, 5'd3, 32'h33);
      chk("t2_c6_stall", 32'(StallReq), 32'd1);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t2_c7", 1, 5'd4, 32'h44);
      chk("t2_c7_stall", 32'(StallReq), 32'd0);
      chk("t2_c7_mask", PendingMask, 32'h0000_0010);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t2_c8", 0, 5'd0, 32'd0);
      chk("t2_c8_mask", PendingMask, 32'd0);
      tick();

      // Kill of a queued entry by a younger pipeline write
      drive(1, 1, 5'd2, 32'h2, 1, 5'd7, 32'h11);
      tick();
      drive(1, 1, 5'd7, 32'h22, 0, 5'd0, 32'd0);
      wr("t3_c1", 1, 5'd7, 32'h22);
      chk("t3_c1_mask", PendingMask, 32'h0000_0080);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t3_c2", 0, 5'd0, 32'd0);
      chk("t3_c2_mask", PendingMask, 32'd0);
      tick();

      // Same-cycle offer killed by the pipeline write to the same register
      drive(1, 1, 5'd9, 32'h90, 1, 5'd9, 32'h99);
      chk("t3s_ready", 32'(MdReady), 32'd1);
      wr("t3s_c0", 1, 5'd9, 32'h90);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t3s_c1", 0, 5'd0, 32'd0);
      chk("t3s_c1_mask", PendingMask, 32'd0);
      tick();

      // Kill of the head with compaction; non-writing pipe op leaves the slot idle
      drive(1, 1, 5'd1, 32'h1, 1, 5'd8, 32'h88);
      tick();
      drive(1, 1, 5'd1, 32'h1, 1, 5'd10, 32'hAA);
      chk("t3k_c1_mask", PendingMask, 32'h0000_0100);
      tick();
      drive(1, 1, 5'd8, 32'hBB, 0, 5'd0, 32'd0);
      wr("t3k_c2", 1, 5'd8, 32'hBB);
      chk("t3k_c2_mask", PendingMask, 32'h0000_0500);
      tick();
      drive(1, 0, 5'd8, 32'hCC, 0, 5'd0, 32'd0);
      wr("t3k_c3", 1, 5'd10, 32'hAA);
      chk("t3k_c3_mask", PendingMask, 32'h0000_0400);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t3k_c4", 0, 5'd0, 32'd0);
      tick();

      // Full queue: pop and refused offer, accepted next cycle; PipeDest 0 counts as idle
      drive(1, 1, 5'd1, 32'h1, 1, 5'd11, 32'hB1);
      tick();
      drive(1, 1, 5'd1, 32'h1, 1, 5'd12, 32'hB2);
      tick();
      drive(0, 0, 5'd0, 32'd0, 1, 5'd13, 32'hB3);
      chk("t4_c2_ready", 32'(MdReady), 32'd0);
      wr("t4_c2", 1, 5'd11, 32'hB1);
      chk("t4_c2_mask", PendingMask, 32'h0000_1800);
      tick();
      drive(0, 0, 5'd0, 32'd0, 1, 5'd13, 32'hB3);
      chk("t4_c3_ready", 32'(MdReady), 32'd1);
      wr("t4_c3", 1, 5'd12, 32'hB2);
      chk("t4_c3_mask", PendingMask, 32'h0000_1000);
      tick();
      drive(1, 1, 5'd0, 32'hEE, 0, 5'd0, 32'd0);
      wr("t4_c4", 1, 5'd13, 32'hB3);
      chk("t4_c4_mask", PendingMask, 32'h0000_2000);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t4_c5", 0, 5'd0, 32'd0);
      tick();

      // Destination 0 is accepted and dropped
      drive(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h55);
      chk("t5_ready", 32'(MdReady), 32'd1);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t5_c1", 0, 5'd0, 32'd0);
      chk("t5_c1_mask", PendingMask, 32'd0);
      tick();

      // Reset with two queued entries discards them
      drive(1, 1, 5'd1, 32'h1, 1, 5'd14, 32'hE1);
      tick();
      drive(1, 1, 5'd1, 32'h1, 1, 5'd15, 32'hE2);
      tick();
      rst = 1'b1;
      drive(0, 0, 5'd0, 32'd0, 1, 5'd16, 32'hE3);
      wr("t6_rst", 0, 5'd0, 32'd0);
      chk("t6_rst_ready", 32'(MdReady), 32'd0);
      chk("t6_rst_mask", PendingMask, 32'd0);
      tick();
      rst = 1'b0;
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t6_c1", 0, 5'd0, 32'd0);
      chk("t6_c1_ready", 32'(MdReady), 32'd1);
      chk("t6_c1_mask", PendingMask, 32'd0);
      tick();
      drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      wr("t6_c2", 0, 5'd0, 32'd0);
      chk("t6_c2_stall", 32'(StallReq), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
